// File: rtl/regbank_dump_reader.sv
// Debug readout engine: walks the register bank through a combinational debug
// read port and streams each captured word out on a valid/ready interface.
module regbank_dump_reader #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_count,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_index,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done
);

  // state  | meaning
  // S_IDLE | waiting for start; limit latched on start
  // S_READ | drive rd_addr=idx, capture word at the edge
  // S_SEND | hold word until the consumer accepts it
  // S_DONE | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = (ADDR_W)'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_limit;
  logic [ADDR_W:0]   w_limit;
  logic              w_last;
  logic              w_xfer;

  assign w_limit = (i_count > MAX_CNT) ? MAX_CNT : i_count;
  assign w_last  = ({1'b0, r_idx} == (r_limit - CNT_ONE));
  assign w_xfer  = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (w_limit == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: w_next = S_SEND;
      S_SEND: begin
        if (w_xfer) begin
          w_next = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // rd_addr follows idx; idx only moves on the way into READ, so the port is quiet otherwise
  always_comb begin
    o_busy    = (r_state != S_IDLE);
    o_done    = (r_state == S_DONE);
    o_rd_addr = r_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_limit     <= '0;
      o_out_valid <= 1'b0;
      o_out_index <= '0;
      o_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_limit <= w_limit;
            if (w_limit != '0) begin
              r_idx <= '0;
            end
          end
        end
        S_READ: begin
          o_out_data  <= i_rd_data;
          o_out_index <= r_idx;
          o_out_valid <= 1'b1;
        end
        S_SEND: begin
          if (w_xfer) begin
            o_out_valid <= 1'b0;
            if (!w_last) begin
              r_idx <= r_idx + IDX_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: bank array on the read port, expected words
// derived from the clamped count, random stalls and random bank contents.
module tb_regbank_dump_reader;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int BUDGET   = 4000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   count = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] bank [NUM_REGS];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_data = bank[rd_addr];

  regbank_dump_reader #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_count(count),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_index(out_index), .o_out_data(out_data),
    .o_busy(busy), .o_done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Runs one dump of cnt words with per-word stalls in
  // [smin,smax]; optionally pulses start again once word restart_at is reached.
  task automatic dump(input int cnt, input int smin, input int smax, input int restart_at);
    int n, cyc, got, stalls, done_cnt, busy_cyc, stall_left, first_valid;
    bit pending, restarted;
    logic [ADDR_W-1:0] prev_idx;
    logic [DATA_W-1:0] prev_data;
    n = (cnt > NUM_REGS) ? NUM_REGS : cnt;
    start = 1'b1;
    count = (ADDR_W+1)'(cnt);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, (n == 0) ? 1 : 0);
    check("valid_after_start", out_valid, 0);
    cyc = 0; got = 0; stalls = 0; done_cnt = 0; busy_cyc = 0;
    first_valid = -1; pending = 0; restarted = 0;
    prev_idx = '0; prev_data = '0;
    stall_left = $urandom_range(smax, smin);
    while (busy === 1'b1 && cyc < BUDGET) begin
      busy_cyc++;
      if (done === 1'b1) done_cnt++;
      if (pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_index", out_index, prev_idx);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (got < n) begin
          check("word_index", out_index, got);
          check("word_data", out_data, bank[got]);
        end else begin
          check("extra_word", got, n - 1);
        end
        check("rd_addr_hold", rd_addr, out_index);
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          stalls++;
          pending = 1;
          prev_idx = out_index;
          prev_data = out_data;
        end else begin
          out_ready = 1'b1;
          got++;
          pending = 0;
          stall_left = $urandom_range(smax, smin);
        end
      end else begin
        out_ready = 1'($urandom_range(1, 0));
        pending = 0;
      end
      if (restart_at >= 0 && got == restart_at && !restarted) begin
        start = 1'b1;
        count = (ADDR_W+1)'(2);
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("dump_timeout", (cyc < BUDGET) ? 1 : 0, 1);
    check("word_count", got, n);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cyc, 2 * n + 1 + stalls);
    check("done_after_end", done, 0);
    check("valid_after_end", out_valid, 0);
    if (n > 0) check("first_valid_cycle", first_valid, 1);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) bank[i] = 32'hA000_0000 + i;

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_rd_addr", rd_addr, 0);
    end

    dump(5, 0, 0, -1);
    dump(3, 4, 4, -1);
    dump(0, 0, 0, -1);
    dump(40, 0, 0, -1);
    dump(6, 0, 0, 3);

    // asynchronous reset while word 2 is waiting in SEND
    start = 1'b1;
    count = (ADDR_W+1)'(6);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !(out_valid === 1'b1 && out_index == 2); k++) @(negedge clk);
    check("reach_word2", (out_valid === 1'b1 && out_index == 2) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_index", out_index, 0);
    check("async_rst_data", out_data, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dump(2, 0, 0, -1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] = $urandom;
      bank[0] = '0;
      dump($urandom_range(40, 0), 0, $urandom_range(3, 0), -1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
